// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared register ids, value layout and index helpers
package reg_file_sb_pkg;

  // Number of architectural entries that occupy storage.
  localparam int REG_FILE_SIZE = 20;
  localparam int REG_IDX_W     = 5;

  // Storage slot of the flags register; flag-only writebacks target it.
  localparam int RFLAGS_IDX    = 16;

  // Storage slot of the stack pointer, which has its own reset value.
  localparam int RSP_IDX       = 4;

  // Ids below REG_FILE_SIZE are real (backed by storage); ids from rnil
  // upward are fake and decode to fixed or externally supplied values.
  typedef enum logic [4:0] {
    rax      = 5'd0,
    rcx      = 5'd1,
    rdx      = 5'd2,
    rbx      = 5'd3,
    rsp      = 5'd4,
    rbp      = 5'd5,
    rsi      = 5'd6,
    rdi      = 5'd7,
    r8       = 5'd8,
    r9       = 5'd9,
    r10      = 5'd10,
    r11      = 5'd11,
    r12      = 5'd12,
    r13      = 5'd13,
    r14      = 5'd14,
    r15      = 5'd15,
    rflags   = 5'd16,
    rt0      = 5'd17,
    rt1      = 5'd18,
    rt2      = 5'd19,
    rnil     = 5'd20,
    rv0      = 5'd21,
    rv8      = 5'd22,
    rip      = 5'd23,
    rimm     = 5'd24,
    rsyscall = 5'd25
  } reg_id_t;

  // Register value: arithmetic flags travel alongside the 64-bit payload.
  typedef struct packed {
    logic        cf;
    logic        zf;
    logic        sf;
    logic        of;
    logic        pf;
    logic        af;
    logic [63:0] val;
  } reg_val_t;

  // True when the id names an entry that has storage and a busy bit.
  function automatic logic reg_in_file(input reg_id_t id);
    return int'(id) < REG_FILE_SIZE;
  endfunction

  // Storage index of a real register.
  function automatic logic [REG_IDX_W-1:0] reg_num(input reg_id_t id);
    return REG_IDX_W'(id);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, issue and writeback bus of the register file
interface reg_file_sb_if;
  import reg_file_sb_pkg::*;

  // Source operand reads (combinational return path).
  reg_id_t     rd_id  [0:1];
  reg_val_t    rd_val [0:1];
  logic [63:0] pc_in;
  logic [63:0] imm_in;

  // Issue handshake: destinations to reserve.
  logic        rsv_valid;
  logic        rsv_ready;
  reg_id_t     rsv_dst [0:1];

  // Writeback ports.
  logic        wb_en       [0:1];
  reg_id_t     wb_dst      [0:1];
  reg_val_t    wb_val      [0:1];
  logic        wb_flags_en [0:1];

  // Illegal access indication.
  logic        err;

  modport master (
    output rd_id, pc_in, imm_in, rsv_valid, rsv_dst,
           wb_en, wb_dst, wb_val, wb_flags_en,
    input  rd_val, rsv_ready, err
  );

  modport slave (
    input  rd_id, pc_in, imm_in, rsv_valid, rsv_dst,
           wb_en, wb_dst, wb_val, wb_flags_en,
    output rd_val, rsv_ready, err
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - busy bits and issue hazard check
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int N = REG_FILE_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  reg_id_t      rd_id   [0:1],
  input  logic         rsv_valid,
  input  reg_id_t      rsv_dst [0:1],
  input  logic         rsv_block,
  input  logic [N-1:0] clr,
  output logic         rsv_ready
);

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_eff;
  logic [N-1:0] set_mask;
  logic         stall;

  // Writebacks landing this cycle already release their entries, so a
  // consumer waiting on them can issue in the same cycle.
  assign busy_eff = busy_q & ~clr;

  // Stall when any real source or destination is still pending.
  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (reg_in_file(rd_id[p]) && busy_eff[reg_num(rd_id[p])]) begin
        stall = 1'b1;
      end
      if (reg_in_file(rsv_dst[p]) && busy_eff[reg_num(rsv_dst[p])]) begin
        stall = 1'b1;
      end
    end
    rsv_ready = !reset && (!rsv_valid || !stall);
  end

  // Entries claimed by an accepted issue; a blocked issue claims nothing.
  always_comb begin
    set_mask = '0;
    if (rsv_valid && rsv_ready && !rsv_block) begin
      for (int p = 0; p < 2; p++) begin
        if (reg_in_file(rsv_dst[p])) begin
          set_mask[reg_num(rsv_dst[p])] = 1'b1;
        end
      end
    end
  end

  // Busy state: set applied after clear so a same-cycle reserve wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_eff | set_mask;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with writeback bypass and issue scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int          REG_FILE_SIZE = reg_file_sb_pkg::REG_FILE_SIZE,
  parameter logic [63:0] RSP_INIT      = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_sb_if.slave bus
);

  reg_val_t                 mem_q  [REG_FILE_SIZE];
  reg_val_t                 mem_nx [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] clr;
  logic                     wb_illegal;
  logic                     rsv_illegal;
  logic                     err_q;

  // Next contents of every entry: the array merged with this cycle's
  // writebacks. Port 1 overrides port 0, and a flags update overrides a
  // direct rflags write in the flag fields only.
  always_comb begin
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      mem_nx[i] = mem_q[i];
    end
    clr = '0;
    for (int p = 0; p < 2; p++) begin
      if (bus.wb_en[p] && reg_in_file(bus.wb_dst[p])) begin
        mem_nx[reg_num(bus.wb_dst[p])] = bus.wb_val[p];
        clr[reg_num(bus.wb_dst[p])]    = 1'b1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (bus.wb_en[p] && bus.wb_flags_en[p] && reg_in_file(bus.wb_dst[p])) begin
        mem_nx[RFLAGS_IDX].cf = bus.wb_val[p].cf;
        mem_nx[RFLAGS_IDX].zf = bus.wb_val[p].zf;
        mem_nx[RFLAGS_IDX].sf = bus.wb_val[p].sf;
        mem_nx[RFLAGS_IDX].of = bus.wb_val[p].of;
        mem_nx[RFLAGS_IDX].pf = bus.wb_val[p].pf;
        mem_nx[RFLAGS_IDX].af = bus.wb_val[p].af;
        clr[RFLAGS_IDX]       = 1'b1;
      end
    end
  end

  // Operand read: fake ids decode to constants or inputs, real ids see the
  // bypassed next contents so a same-cycle writeback is visible.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bus.rd_val[p] = '0;
      case (bus.rd_id[p])
        rv8:     bus.rd_val[p].val = 64'd8;
        rip:     bus.rd_val[p].val = bus.pc_in;
        rimm:    bus.rd_val[p].val = bus.imm_in;
        default: begin
          if (reg_in_file(bus.rd_id[p])) begin
            bus.rd_val[p] = mem_nx[reg_num(bus.rd_id[p])];
          end
        end
      endcase
    end
  end

  // Illegal accesses: writeback to a fake id, or reserving rip/rimm.
  always_comb begin
    wb_illegal = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (bus.wb_en[p] && !reg_in_file(bus.wb_dst[p])) begin
        wb_illegal = 1'b1;
      end
    end
    rsv_illegal = bus.rsv_valid &&
                  (bus.rsv_dst[0] == rip || bus.rsv_dst[0] == rimm ||
                   bus.rsv_dst[1] == rip || bus.rsv_dst[1] == rimm);
  end

  // Storage update; reset discards any same-cycle writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (reset) begin
        mem_q[i] <= (i == RSP_IDX) ? reg_val_t'({6'b0, RSP_INIT}) : '0;
      end else begin
        mem_q[i] <= mem_nx[i];
      end
    end
  end

  // One-cycle error pulse following an illegal access.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wb_illegal || rsv_illegal;
    end
  end

  assign bus.err = err_q;

  reg_scoreboard #(
    .N (REG_FILE_SIZE)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rd_id     (bus.rd_id),
    .rsv_valid (bus.rsv_valid),
    .rsv_dst   (bus.rsv_dst),
    .rsv_block (rsv_illegal),
    .clr       (clr),
    .rsv_ready (bus.rsv_ready)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and random checks of reg_file_sb against a model
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam logic [63:0] RSP_INIT_TB = 64'h7fff0000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_sb_if bus ();

  reg_file_sb #(.RSP_INIT(RSP_INIT_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural model: values, pending flags, error pulse.
  reg_val_t m_val  [20];
  bit       m_busy [20];
  bit       m_err;

  function automatic bit m_real(input reg_id_t id);
    return id <= rt2;
  endfunction

  function automatic bit m_flags_upd(input int p);
    return bus.wb_en[p] && bus.wb_flags_en[p] && m_real(bus.wb_dst[p]);
  endfunction

  function automatic bit m_cleared(input reg_id_t id);
    bit c = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (bus.wb_en[p] && bus.wb_dst[p] == id) c = 1'b1;
      if (id == rflags && m_flags_upd(p)) c = 1'b1;
    end
    return c;
  endfunction

  function automatic reg_val_t m_read(input reg_id_t id);
    reg_val_t r = '0;
    if (id == rv8) r.val = 64'd8;
    else if (id == rip) r.val = bus.pc_in;
    else if (id == rimm) r.val = bus.imm_in;
    else if (m_real(id)) begin
      r = m_val[int'(id)];
      for (int p = 0; p < 2; p++)
        if (bus.wb_en[p] && bus.wb_dst[p] == id) r = bus.wb_val[p];
      if (id == rflags)
        for (int p = 0; p < 2; p++)
          if (m_flags_upd(p)) begin
            r.cf = bus.wb_val[p].cf; r.zf = bus.wb_val[p].zf;
            r.sf = bus.wb_val[p].sf; r.of = bus.wb_val[p].of;
            r.pf = bus.wb_val[p].pf; r.af = bus.wb_val[p].af;
          end
    end
    return r;
  endfunction

  function automatic bit m_rsv_bad();
    return bus.rsv_valid && (bus.rsv_dst[0] inside {rip, rimm} || bus.rsv_dst[1] inside {rip, rimm});
  endfunction

  function automatic bit m_pending(input reg_id_t id);
    return m_real(id) && m_busy[int'(id)] && !m_cleared(id);
  endfunction

  function automatic bit m_ready();
    if (reset) return 1'b0;
    if (!bus.rsv_valid) return 1'b1;
    return !(m_pending(bus.rd_id[0]) || m_pending(bus.rd_id[1]) ||
             m_pending(bus.rsv_dst[0]) || m_pending(bus.rsv_dst[1]));
  endfunction

  task automatic m_tick();
    reg_val_t nv [20];
    bit       nb [20];
    bit       rdy;
    bit       e;
    if (reset) begin
      for (int i = 0; i < 20; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; end
      m_val[int'(rsp)].val = RSP_INIT_TB;
      m_err = 1'b0;
    end else begin
      rdy = m_ready();
      for (int i = 0; i < 20; i++) begin
        nv[i] = m_read(reg_id_t'(i));
        nb[i] = m_busy[i] && !m_cleared(reg_id_t'(i));
      end
      if (bus.rsv_valid && rdy && !m_rsv_bad())
        for (int p = 0; p < 2; p++)
          if (m_real(bus.rsv_dst[p])) nb[int'(bus.rsv_dst[p])] = 1'b1;
      e = m_rsv_bad();
      for (int p = 0; p < 2; p++)
        if (bus.wb_en[p] && !m_real(bus.wb_dst[p])) e = 1'b1;
      m_err = e;
      for (int i = 0; i < 20; i++) begin m_val[i] = nv[i]; m_busy[i] = nb[i]; end
    end
  endtask

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd0"}, bus.rd_val[0], m_read(bus.rd_id[0]));
    chk({tag, ".rd1"}, bus.rd_val[1], m_read(bus.rd_id[1]));
    chk({tag, ".ready"}, 70'(bus.rsv_ready), 70'(m_ready()));
    chk({tag, ".err"}, 70'(bus.err), 70'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      bus.rd_id[p] = rnil; bus.rsv_dst[p] = rnil;
      bus.wb_en[p] = 1'b0; bus.wb_dst[p] = rnil;
      bus.wb_val[p] = '0; bus.wb_flags_en[p] = 1'b0;
    end
    bus.rsv_valid = 1'b0;
    bus.pc_in = '0;
    bus.imm_in = '0;
  endtask

  function automatic reg_id_t rnd_rsv();
    int r = $urandom_range(0, 31);
    if (r < 20) return reg_id_t'(r);
    if (r == 20) return rip;
    if (r == 21) return rimm;
    return rnil;
  endfunction

  initial begin
    reg_val_t v;
    reg_val_t e;
    for (int i = 0; i < 20; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; end
    m_err = 1'b0;
    reset = 1'b1;
    idle();
    cyc();
    bus.rsv_valid = 1'b1;
    @(negedge clk);
    chk("rst.ready_low", 70'(bus.rsv_ready), 70'd0);
    cyc();
    reset = 1'b0;
    idle();

    // Reset contents
    bus.rd_id[0] = rsp; bus.rd_id[1] = rax;
    @(negedge clk);
    chk("rst.rsp", bus.rd_val[0], {6'b0, RSP_INIT_TB});
    chk("rst.rax", bus.rd_val[1], 70'd0);
    chk("rst.ready", 70'(bus.rsv_ready), 70'd1);
    check_all("rst");
    cyc();

    // Reserve then stall, released by same-cycle writeback
    idle(); bus.rsv_valid = 1'b1; bus.rsv_dst[0] = rax;
    @(negedge clk);
    check_all("rsv");
    cyc();
    idle(); bus.rsv_valid = 1'b1; bus.rd_id[0] = rax;
    @(negedge clk);
    chk("stall.ready", 70'(bus.rsv_ready), 70'd0);
    bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rax; bus.wb_val[0] = 70'h5;
    #1;
    chk("release.ready", 70'(bus.rsv_ready), 70'd1);
    chk("release.rd0", bus.rd_val[0], 70'h5);
    cyc();

    // Dual write, port 1 wins
    idle();
    bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rcx; bus.wb_val[0] = 70'd1;
    bus.wb_en[1] = 1'b1; bus.wb_dst[1] = rcx; bus.wb_val[1] = 70'd2;
    cyc();
    idle(); bus.rd_id[0] = rcx;
    @(negedge clk);
    chk("dual.rcx", bus.rd_val[0], 70'd2);
    cyc();

    // Reserve beats writeback clear on the same register
    idle();
    bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rbx; bus.wb_val[0] = 70'h77;
    bus.rsv_valid = 1'b1; bus.rsv_dst[0] = rbx;
    @(negedge clk);
    check_all("prio");
    cyc();
    idle(); bus.rsv_valid = 1'b1; bus.rd_id[0] = rbx;
    @(negedge clk);
    chk("prio.val", bus.rd_val[0], 70'h77);
    chk("prio.busy", 70'(bus.rsv_ready), 70'd0);
    cyc();
    idle(); bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rbx; bus.wb_val[0] = 70'h78;
    cyc();

    // Flags writeback
    idle();
    v = '0; v.cf = 1'b1; v.zf = 1'b1; v.val = 64'h99;
    bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rdx; bus.wb_val[0] = v; bus.wb_flags_en[0] = 1'b1;
    cyc();
    idle(); bus.rsv_valid = 1'b1; bus.rd_id[0] = rflags; bus.rd_id[1] = rdx;
    @(negedge clk);
    e = '0; e.cf = 1'b1; e.zf = 1'b1;
    chk("flags.rflags", bus.rd_val[0], e);
    chk("flags.rdx", bus.rd_val[1], v);
    chk("flags.not_busy", 70'(bus.rsv_ready), 70'd1);
    cyc();

    // Fake registers and illegal writeback
    idle(); bus.rd_id[0] = rv8; bus.rd_id[1] = rimm; bus.imm_in = 64'h1234;
    @(negedge clk);
    chk("fake.rv8", bus.rd_val[0], 70'd8);
    chk("fake.rimm", bus.rd_val[1], 70'h1234);
    cyc();
    idle(); bus.pc_in = 64'h4000; bus.rd_id[0] = rip;
    bus.wb_en[0] = 1'b1; bus.wb_dst[0] = rip; bus.wb_val[0] = 70'hdead;
    @(negedge clk);
    chk("fake.err_before", 70'(bus.err), 70'd0);
    cyc();
    idle(); bus.pc_in = 64'h4000; bus.rd_id[0] = rip;
    @(negedge clk);
    chk("fake.err", 70'(bus.err), 70'd1);
    chk("fake.rip", bus.rd_val[0], 70'h4000);
    cyc();
    @(negedge clk);
    chk("fake.err_clear", 70'(bus.err), 70'd0);
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      bus.pc_in = {$urandom, $urandom};
      bus.imm_in = {$urandom, $urandom};
      bus.rsv_valid = $urandom_range(0, 1) == 1;
      for (int p = 0; p < 2; p++) begin
        bus.rd_id[p] = reg_id_t'($urandom_range(0, 25));
        bus.rsv_dst[p] = rnd_rsv();
        bus.wb_en[p] = $urandom_range(0, 1) == 1;
        bus.wb_dst[p] = reg_id_t'($urandom_range(0, 20));
        bus.wb_val[p] = {6'($urandom), $urandom, $urandom};
        bus.wb_flags_en[p] = $urandom_range(0, 3) == 0;
      end
      @(negedge clk);
      check_all("rand");
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 20 (taken from the shared package), meaning the number of architectural entries.
REQ-002 SHALL have parameter RSP_INIT, default 64'h0, meaning the reset value of the rsp entry.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have read ports rd_id[0:1], input, reg_id_t: source register ids.
REQ-006 SHALL have read ports rd_val[0:1], output, reg_val_t: source values; combinational.
REQ-007 SHALL have pc_in, input, 64 bits: the value returned for rip.
REQ-008 SHALL have imm_in, input, 64 bits: the value returned for rimm.
REQ-009 SHALL have rsv_valid, input, 1 bit: decode requests issue.
REQ-010 SHALL have rsv_ready, output, 1 bit: issue is accepted this cycle.
REQ-011 SHALL have rsv_dst[0:1], input, reg_id_t: destinations to mark busy; rnil means none.
REQ-012 SHALL have wb_en[0:1], input, 1 bit: writeback strobes.
REQ-013 SHALL have wb_dst[0:1], input, reg_id_t: writeback destinations.
REQ-014 SHALL have wb_val[0:1], input, reg_val_t: writeback data, carrying flag fields and val.
REQ-015 SHALL have wb_flags_en[0:1], input, 1 bit: also update the rflags flag fields.
REQ-016 SHALL have err, output, 1 bit: registered one-cycle pulse on an illegal access.

Function
REQ-017 Storage SHALL be REG_FILE_SIZE entries of reg_val_t plus one busy bit per entry, indexed by reg_num(id).
REQ-018 Reads of fake registers SHALL return fixed values: rnil and rv0 give val 0, rv8 gives val 8, rip gives pc_in, rimm gives imm_in, and rsyscall gives 0. All flag fields SHALL be 0, and fake registers SHALL never be busy.
REQ-019 Reads of real registers SHALL return the array entry, bypassed from any same-cycle wb write to that entry; when both ports write the entry, port 1 SHALL win.
REQ-020 rsv_ready SHALL be 1 exactly when, after clearing same-cycle wb destinations, no real register named in rd_id[0:1] or rsv_dst[0:1] is busy. rsv_ready SHALL be 1 when rsv_valid=0.
REQ-021 When rsv_valid and rsv_ready are both 1, busy SHALL be set on the next edge for every real rsv_dst. Otherwise no busy bit SHALL be set.
REQ-022 A wb_en write SHALL update the entry and clear its busy bit on the next edge.
REQ-023 When a wb clear and an accepted reserve hit the same register in the same cycle, the reserve SHALL win: the value is written and busy stays 1.
REQ-024 When wb_flags_en is set, the wb SHALL update the rflags entry flag fields (cf, zf, sf, of, pf, af) and clear rflags busy. A direct wb_dst=rflags write SHALL take lower priority than a flags_en update.
REQ-025 wb_en to a fake register, or rsv_dst equal to rip or rimm, SHALL leave the state unchanged and SHALL assert err the next cycle.
REQ-026 Write latency SHALL be 1 cycle; read latency SHALL be 0 cycles.

Reset
REQ-027 On reset=1 at an edge, all entries SHALL become 0 except rsp, which SHALL become RSP_INIT.
REQ-028 On reset, all busy bits SHALL clear and err SHALL become 0.
REQ-029 A reset asserted in the same cycle as a wb or reserve SHALL take priority, so no update is retained.
REQ-030 While reset=1, rsv_ready SHALL be driven 0.

Structure
REQ-031 reg_id_t, reg_val_t, REG_FILE_SIZE, reg_in_file and reg_num SHALL come from the shared register package.
REQ-032 A new constant RFLAGS_IDX=16 SHALL be added to the shared register package.
REQ-033 The busy-bit logic SHALL be a sub-module named reg_scoreboard, instantiated once.

Verification
REQ-034 Reset test: assert reset with RSP_INIT=64'h7fff0000, then read rsp and rax -> 64'h7fff0000 and 0; rsv_ready=1.
REQ-035 Reserve and stall test: reserve rax, then next cycle read rax with rsv_valid -> rsv_ready=0. Apply wb rax=64'h5 -> same cycle rsv_ready=1 and rd_val=5.
REQ-036 Dual-write test: wb port0 rcx=1 and port1 rcx=2 in one cycle -> rcx=2.
REQ-037 Reserve-priority test: wb rbx and reserve rbx in one cycle -> rbx busy=1 and value updated.
REQ-038 Flags test: wb rdx with wb_flags_en=1, zf=1, cf=1 -> rflags zf=1, cf=1, others 0, and rflags not busy.
REQ-039 Fake-register test: read rv8 -> val 8; read rimm with imm_in=64'h1234 -> val 64'h1234; wb to rip -> err=1 next cycle and nothing written.
